// File: rtl/iter_addsub_pkg.sv
// Shared definitions for the iterative chunked adder/subtractor.
package iter_addsub_pkg;

  // Control FSM states; also exported on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Operation select encoding for op_sub.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Chunk counter width: enough bits to index every chunk, never less than 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iter_addsub_chunk_adder.sv
// One CHUNK-bit slice of a ripple adder. Also reports the carry into its
// top bit so the caller can form signed overflow on the final slice.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] full;

  // Plain binary add with one extra bit for the carry out; the carry into the
  // MSB is recovered from the MSB sum bit and its two operand bits.
  always_comb begin
    full     = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    sum      = full[CHUNK-1:0];
    cout     = full[CHUNK];
    c_msb_in = full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
  end

endmodule

// File: rtl/iter_addsub.sv
// Iterative add/subtract: processes CHUNK bits per cycle, LSB chunk first,
// through a single shared chunk_adder. Latency is WIDTH/CHUNK cycles from
// accept to result_valid.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. start_ready is high only in IDLE; result_valid is high only in DONE
// and the result/flags stay frozen until result_ready completes the transfer.
module iter_addsub
  import iter_addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [1:0]       dbg_state_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = cnt_width(NCHUNK);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             op_q;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             accept;
  int unsigned      shamt;
  logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
  logic             chunk_cout, chunk_c_msb;

  assign accept = start_valid && (state_q == ST_IDLE);

  // Select the current chunk of each operand; B is inverted for subtract.
  always_comb begin
    shamt   = 32'(cnt_q) * CHUNK;
    a_chunk = CHUNK'(a_q >> shamt);
    b_chunk = (op_q == OP_ADD) ? CHUNK'(b_q >> shamt) : ~CHUNK'(b_q >> shamt);
  end

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a        (a_chunk),
    .b        (b_chunk),
    .cin      (carry_q),
    .sum      (sum_chunk),
    .cout     (chunk_cout),
    .c_msb_in (chunk_c_msb)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          // Subtract is A + ~B + 1: the +1 enters as carry-in of chunk 0.
          carry_d = (op_sub == OP_SUB);
          acc_d   = '0;
        end
      end
      ST_RUN: begin
        acc_d   = (acc_q & ~(CHUNK_MASK << shamt)) | (WIDTH'(sum_chunk) << shamt);
        carry_d = chunk_cout;
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          res_d   = acc_d;
          cout_d  = chunk_cout;
          ovf_d   = chunk_cout ^ chunk_c_msb;
          zero_d  = (acc_d == '0);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (result_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller, chunk counter, carry and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  // Operands are captured only at accept so later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= 1'b0;
    end else if (accept) begin
      a_q  <= input_a;
      b_q  <= input_b;
      op_q <= op_sub;
    end
  end

  assign start_ready  = (state_q == ST_IDLE);
  assign result_valid = (state_q == ST_DONE);
  assign result       = res_q;
  assign carry_out    = cout_q;
  assign overflow     = ovf_q;
  assign zero         = zero_q;
  assign dbg_state_o  = state_q;

endmodule
